pixel_stream_receiver: RTL and testbench
========================================

// Module: pixel_stream_receiver
// PURPOSE
//  AXI4-Stream video sink: the receiving end of the packed RGB stream the pixel generator emits.
//  Unpacks 4 pixels from 3 x 32-bit words, tracks x/y, and flags SOF/EOL framing errors.
//  Drives a pixel-wide valid/ready output for the sim scoreboard or a downstream display model.
// PARAMETERS
//  WIDTH    640  active pixels per line; must be a multiple of 4
//  HEIGHT   480  lines per frame
// PORTS
//  aclk              in   1   sole clock
//  aresetn           in   1   reset; synchronous, active-low
//  in_stream_tdata   in   32  packed pixel bytes
//  in_stream_tkeep   in   4   not examined; all 4 bytes always valid
//  in_stream_tlast   in   1   end-of-line marker, on the last word of a line
//  in_stream_tuser   in   1   start-of-frame marker, on the first word of a frame
//  in_stream_tvalid  in   1   word valid
//  in_stream_tready  out  1   word accepted when tvalid&tready
//  pix_r/pix_g/pix_b out  8   unpacked pixel (pixel = {r,g,b}, r in bits 23:16)
//  pix_x             out  16  column, 0..WIDTH-1
//  pix_y             out  16  row, 0..HEIGHT-1
//  pix_sof/pix_eol   out  1   pixel is (0,0) / x==WIDTH-1
//  pix_valid         out  1   output pixel valid
//  pix_ready         in   1   downstream accepts when pix_valid&pix_ready
//  frame_count       out  16  accepted tuser words; wraps
//  err_sof/err_eol   out  8   saturating framing-error counters
// BEHAVIOUR
//  Reset: tready=0 during reset; pix_valid=0; all counters, x, y and phase = 0; residue discarded.
//  Unpacking: byte lanes b0=tdata[7:0]..b3=tdata[31:24]; phase register P with values 0..3.
//   P0 word: pixel={b2,b1,b0}, residue<=b3, P->1
//   P1 word: pixel={b1,b0,res[7:0]}, residue<={b3,b2}, P->2
//   P2 word: pixel={b0,res[15:0]}, residue<={b3,b2,b1}, P->3
//   P3 (holding a full pixel, no word consumed): pixel=residue, P->0
//  Handshake: out_free = !pix_valid | pix_ready.
//   tready = out_free & (P!=3).
//   In P3 the pixel is emitted when out_free.
//   Output regs load on every produced pixel; pix_valid clears when taken and nothing new is produced.
//   Latency: accepted word -> pix_valid on the next cycle. Full rate: 4 pixels per 4 cycles, tready low in P3.
//  Coordinates: x++ per emitted pixel; at x==WIDTH-1, x<=0 and y++; at y==HEIGHT-1, y wraps to 0.
//   Outputs carry the coordinates of the pixel held in the output register.
//  SOF: accepted word with tuser=1 increments frame_count.
//   If P!=0 or (x,y)!=(0,0): err_sof++, residue dropped, word decoded as a P0 word, x=y=0.
//  EOL: a correct tlast arrives on the P2 word whose held (P3) pixel has x==WIDTH-1; that pixel gets pix_eol.
//   tlast on any other word: err_eol++; the pixel from this word is emitted with pix_eol=1;
//   residue dropped, P->0, x->0, y++.
//   Held pixel reaching x==WIDTH-1 without tlast on its word: err_eol++; coordinates still wrap.
//  Simultaneous tuser&tlast on one word: SOF resync is applied first, then the EOL check.
//  Error counters stick at 255. pix_ready low stalls everything: tready=0, no state changes.
// STRUCTURE
//  Package pix_stream_pkg: PIX_BYTES=3, WORD_BYTES=4, phase encodings P0..P3,
//   function pack_rgb(r,g,b)->24b shared with the packer model.
//  Single flat module; no sub-module required (unpack mux + counters ~250 lines).
// TESTING
//  1. Reset, then 1 line WIDTH=8 of 6 words, tuser on w0, tlast on w5, pix_ready=1
//     -> 8 pixels with x=0..7, pix_sof on x0, pix_eol on x7, errs=0.
//  2. Words 0x44332211,0x88776655,0xCCBBAA99 -> pixels 0x332211, 0x665544, 0x998877, 0xCCBBAA,
//     in order; tready=0 during the 4th pixel.
//  3. pix_ready toggled 1010... over a full frame -> no pixel lost or duplicated; tready never 1 in P3.
//  4. tuser on a P1 word mid-line -> err_sof=1, that word's pixel is (0,0) with pix_sof,
//     frame_count incremented.
//  5. tlast on a P1 word -> err_eol=1, that pixel has pix_eol, next word starts at x=0, y+1;
//     missing tlast -> err_eol++.
//  6. aresetn low for 1 cycle mid-line with pix_valid=1 -> pix_valid=0 next cycle, P=0,
//     counters 0, next tuser word decodes cleanly.

Source files
------------

// File: rtl/pix_stream_pkg.sv
// Shared constants and helpers for the packed-RGB stream: byte counts, unpack
// phase encodings and the pixel packing function used by both ends of the link.
package pix_stream_pkg;

    localparam int PIX_BYTES  = 3;
    localparam int WORD_BYTES = 4;

    localparam logic [1:0] PH_P0 = 2'd0;
    localparam logic [1:0] PH_P1 = 2'd1;
    localparam logic [1:0] PH_P2 = 2'd2;
    localparam logic [1:0] PH_P3 = 2'd3;

    function automatic logic [8*PIX_BYTES-1:0] pack_rgb(input logic [7:0] r,
                                                        input logic [7:0] g,
                                                        input logic [7:0] b);
        return {r, g, b};
    endfunction

endpackage

// File: rtl/pixel_stream_receiver_if.sv
// AXI4-Stream word channel carrying packed RGB bytes, with source (master)
// and sink (slave) views.
interface pixel_stream_receiver_if;
    import pix_stream_pkg::*;

    logic [8*WORD_BYTES-1:0] tdata;
    logic [WORD_BYTES-1:0]   tkeep;
    logic                    tlast;
    logic                    tuser;
    logic                    tvalid;
    logic                    tready;

    modport master (output tdata, output tkeep, output tlast, output tuser,
                    output tvalid, input tready);
    modport slave  (input tdata, input tkeep, input tlast, input tuser,
                    input tvalid, output tready);
endinterface

// File: rtl/pixel_stream_receiver.sv
// Video sink: unpacks 4 RGB pixels from every 3 stream words, tracks x/y
// coordinates and counts start-of-frame / end-of-line framing errors.
module pixel_stream_receiver
    import pix_stream_pkg::*;
#(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    pixel_stream_receiver_if.slave  in_stream,
    output logic [7:0]              pix_r,
    output logic [7:0]              pix_g,
    output logic [7:0]              pix_b,
    output logic [15:0]             pix_x,
    output logic [15:0]             pix_y,
    output logic                    pix_sof,
    output logic                    pix_eol,
    output logic                    pix_valid,
    input  logic                    pix_ready,
    output logic [15:0]             frame_count,
    output logic [7:0]              err_sof,
    output logic [7:0]              err_eol
);

    localparam logic [15:0] X_LAST    = 16'(WIDTH - 1);
    localparam logic [15:0] X_PRELAST = 16'(WIDTH - 2);
    localparam logic [15:0] Y_LAST    = 16'(HEIGHT - 1);

    logic [1:0]  phase_r;
    logic [23:0] res_r;
    logic [15:0] x_r, y_r;
    logic        last_pend_r;
    logic [23:0] pix_rgb_r;
    logic [15:0] pix_x_r, pix_y_r;
    logic        pix_sof_r, pix_eol_r, pix_valid_r;
    logic [15:0] frame_count_r;
    logic [7:0]  err_sof_r, err_eol_r;

    logic [7:0]  b0_s, b1_s, b2_s, b3_s;
    logic        out_free_s, tready_s, word_acc_s, produce_s, held_s;
    logic        sof_word_s, tlast_acc_s, sof_err_s;
    logic [1:0]  phase_e_s, phase_n_s;
    logic [15:0] x_e_s, y_e_s, x_n_s, y_n_s;
    logic [23:0] pixel_s, res_n_s;
    logic        x_last_s, eol_ok_s, eol_bad_s, eol_miss_s, wrap_s;
    logic        unused_tkeep_s;

    assign b0_s = in_stream.tdata[7:0];
    assign b1_s = in_stream.tdata[15:8];
    assign b2_s = in_stream.tdata[23:16];
    assign b3_s = in_stream.tdata[31:24];
    assign unused_tkeep_s = ^in_stream.tkeep;

    // A held pixel (P3) occupies the cycle, so no word is taken then.
    assign out_free_s  = !pix_valid_r || pix_ready;
    assign tready_s    = aresetn && out_free_s && (phase_r != PH_P3);
    assign word_acc_s  = in_stream.tvalid && tready_s;
    assign produce_s   = word_acc_s || ((phase_r == PH_P3) && out_free_s);
    assign held_s      = produce_s && !word_acc_s;
    assign sof_word_s  = word_acc_s && in_stream.tuser;
    assign tlast_acc_s = word_acc_s && in_stream.tlast;
    assign in_stream.tready = tready_s;

    // Start-of-frame resync: a tuser word restarts decoding as a P0 word at (0,0).
    always_comb begin
        if (sof_word_s) begin
            phase_e_s = PH_P0;
            x_e_s     = 16'd0;
            y_e_s     = 16'd0;
            sof_err_s = (phase_r != PH_P0) || (x_r != 16'd0) || (y_r != 16'd0);
        end else begin
            phase_e_s = phase_r;
            x_e_s     = x_r;
            y_e_s     = y_r;
            sof_err_s = 1'b0;
        end
    end

    // Unpack mux: pixel bytes for this phase and the residue carried forward.
    always_comb begin
        pixel_s   = res_r;
        res_n_s   = res_r;
        phase_n_s = PH_P0;
        case (phase_e_s)
            PH_P0: begin
                pixel_s   = pack_rgb(b2_s, b1_s, b0_s);
                res_n_s   = {16'h0000, b3_s};
                phase_n_s = PH_P1;
            end
            PH_P1: begin
                pixel_s   = pack_rgb(b1_s, b0_s, res_r[7:0]);
                res_n_s   = {8'h00, b3_s, b2_s};
                phase_n_s = PH_P2;
            end
            PH_P2: begin
                pixel_s   = pack_rgb(b0_s, res_r[15:8], res_r[7:0]);
                res_n_s   = {b3_s, b2_s, b1_s};
                phase_n_s = PH_P3;
            end
            PH_P3: begin
                pixel_s   = res_r;
                res_n_s   = res_r;
                phase_n_s = PH_P0;
            end
            default: begin
                pixel_s   = res_r;
                res_n_s   = res_r;
                phase_n_s = PH_P0;
            end
        endcase
    end

    // Line framing: a proper tlast rides on the P2 word whose held pixel ends the line.
    always_comb begin
        x_last_s   = (x_e_s == X_LAST);
        eol_ok_s   = tlast_acc_s && (phase_e_s == PH_P2) && (x_e_s == X_PRELAST);
        eol_bad_s  = tlast_acc_s && !eol_ok_s;
        eol_miss_s = produce_s && x_last_s && !eol_bad_s && !(held_s && last_pend_r);
        wrap_s     = x_last_s || eol_bad_s;
        if (wrap_s) begin
            x_n_s = 16'd0;
            y_n_s = (y_e_s == Y_LAST) ? 16'd0 : (y_e_s + 16'd1);
        end else begin
            x_n_s = x_e_s + 16'd1;
            y_n_s = y_e_s;
        end
    end

    // Datapath, coordinate and counter registers.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            phase_r       <= PH_P0;
            res_r         <= 24'h000000;
            x_r           <= 16'd0;
            y_r           <= 16'd0;
            last_pend_r   <= 1'b0;
            pix_rgb_r     <= 24'h000000;
            pix_x_r       <= 16'd0;
            pix_y_r       <= 16'd0;
            pix_sof_r     <= 1'b0;
            pix_eol_r     <= 1'b0;
            pix_valid_r   <= 1'b0;
            frame_count_r <= 16'd0;
            err_sof_r     <= 8'd0;
            err_eol_r     <= 8'd0;
        end else begin
            if (produce_s) begin
                phase_r     <= eol_bad_s ? PH_P0 : phase_n_s;
                res_r       <= res_n_s;
                x_r         <= x_n_s;
                y_r         <= y_n_s;
                last_pend_r <= eol_ok_s;
                pix_rgb_r   <= pixel_s;
                pix_x_r     <= x_e_s;
                pix_y_r     <= y_e_s;
                pix_sof_r   <= (x_e_s == 16'd0) && (y_e_s == 16'd0);
                pix_eol_r   <= x_last_s || eol_bad_s;
                pix_valid_r <= 1'b1;
            end else if (pix_ready) begin
                pix_valid_r <= 1'b0;
            end else begin
                pix_valid_r <= pix_valid_r;
            end
            if (sof_word_s) begin
                frame_count_r <= frame_count_r + 16'd1;
            end else begin
                frame_count_r <= frame_count_r;
            end
            if (sof_err_s && (err_sof_r != 8'hFF)) begin
                err_sof_r <= err_sof_r + 8'd1;
            end else begin
                err_sof_r <= err_sof_r;
            end
            if ((eol_bad_s || eol_miss_s) && (err_eol_r != 8'hFF)) begin
                err_eol_r <= err_eol_r + 8'd1;
            end else begin
                err_eol_r <= err_eol_r;
            end
        end
    end

    assign pix_r       = pix_rgb_r[23:16];
    assign pix_g       = pix_rgb_r[15:8];
    assign pix_b       = pix_rgb_r[7:0];
    assign pix_x       = pix_x_r;
    assign pix_y       = pix_y_r;
    assign pix_sof     = pix_sof_r;
    assign pix_eol     = pix_eol_r;
    assign pix_valid   = pix_valid_r;
    assign frame_count = frame_count_r;
    assign err_sof     = err_sof_r;
    assign err_eol     = err_eol_r;

endmodule

// File: tb/tb_pixel_stream_receiver.sv
// Directed bench for pixel_stream_receiver with an 8x4 frame geometry.
module tb_pixel_stream_receiver;
    import pix_stream_pkg::*;

    localparam int W = 8;
    localparam int H = 4;

    typedef struct packed {
        logic [23:0] rgb;
        logic [15:0] x;
        logic [15:0] y;
        logic        sof;
        logic        eol;
    } pix_t;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        pix_ready;
    logic [7:0]  pix_r, pix_g, pix_b;
    logic [15:0] pix_x, pix_y;
    logic        pix_sof, pix_eol, pix_valid;
    logic [15:0] frame_count;
    logic [7:0]  err_sof, err_eol;

    pixel_stream_receiver_if in_if();

    pixel_stream_receiver #(.WIDTH(W), .HEIGHT(H)) dut (
        .aclk(aclk), .aresetn(aresetn), .in_stream(in_if),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .pix_x(pix_x), .pix_y(pix_y), .pix_sof(pix_sof), .pix_eol(pix_eol),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .frame_count(frame_count), .err_sof(err_sof), .err_eol(err_eol)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;
    logic [31:0] wq_data[$];
    bit          wq_user[$];
    bit          wq_last[$];
    pix_t        got_q[$];
    pix_t        exp_q[$];
    int          p3_viol;
    int          p3_seen;
    bit          timed_out;

    function automatic logic [7:0] bt(input logic [7:0] seed, input int i);
        return seed + 8'(i);
    endfunction

    function automatic logic [31:0] word_at(input logic [7:0] seed, input int k);
        return {bt(seed, 4*k+3), bt(seed, 4*k+2), bt(seed, 4*k+1), bt(seed, 4*k)};
    endfunction

    // Pixel i of a byte stream that starts at byte offset off.
    function automatic logic [23:0] pix_at(input logic [7:0] seed, input int off, input int i);
        return pack_rgb(bt(seed, off+3*i+2), bt(seed, off+3*i+1), bt(seed, off+3*i));
    endfunction

    task automatic clear_q();
        wq_data.delete(); wq_user.delete(); wq_last.delete(); exp_q.delete();
    endtask

    task automatic push_word(input logic [31:0] d, input bit u, input bit l);
        wq_data.push_back(d); wq_user.push_back(u); wq_last.push_back(l);
    endtask

    task automatic push_exp(input logic [23:0] rgb, input int x, input int y, input bit sof, input bit eol);
        pix_t p;
        p.rgb = rgb; p.x = 16'(x); p.y = 16'(y); p.sof = sof; p.eol = eol;
        exp_q.push_back(p);
    endtask

    // Drives queued words, collects accepted pixels, tracks the held-pixel (P3) cycles.
    task automatic run_stream(input int nw, input int exp_n, input bit toggle, input bit p3chk);
        int wi = 0;
        int cyc = 0;
        int idle = 0;
        int acc = 0;
        bit held = 1'b0;
        pix_t g;
        got_q.delete(); p3_viol = 0; p3_seen = 0; timed_out = 1'b0;
        while (idle < 4 && cyc < 2000) begin
            @(negedge aclk);
            pix_ready = toggle ? ((cyc % 2) == 0) : 1'b1;
            if (wi < nw) begin
                in_if.tvalid = 1'b1; in_if.tdata = wq_data[wi];
                in_if.tuser = wq_user[wi]; in_if.tlast = wq_last[wi];
            end else begin
                in_if.tvalid = 1'b0; in_if.tuser = 1'b0; in_if.tlast = 1'b0;
            end
            #1;
            if (pix_valid && pix_ready) begin
                g.rgb = pack_rgb(pix_r, pix_g, pix_b);
                g.x = pix_x; g.y = pix_y; g.sof = pix_sof; g.eol = pix_eol;
                got_q.push_back(g);
            end
            if (held) begin
                p3_seen++;
                if (p3chk && in_if.tready) p3_viol++;
                if (!pix_valid || pix_ready) held = 1'b0;
            end else if (in_if.tvalid && in_if.tready) begin
                acc++;
                if ((acc % 3) == 0) held = 1'b1;
            end
            if (in_if.tvalid && in_if.tready) wi++;
            if (wi == nw && got_q.size() >= exp_n) idle++;
            cyc++;
        end
        if (cyc >= 2000) timed_out = 1'b1;
        in_if.tvalid = 1'b0;
    endtask

    task automatic test_reset();
        aresetn = 1'b0; pix_ready = 1'b1; in_if.tvalid = 1'b1; in_if.tdata = 32'h0;
        in_if.tuser = 1'b0; in_if.tlast = 1'b0; in_if.tkeep = 4'hF;
        repeat (2) @(posedge aclk);
        #1;
        checks++; if (in_if.tready !== 1'b0) begin errors++; $display("FAIL rst_tready: got %b, expected 0", in_if.tready); end
        checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL rst_pix_valid: got %b, expected 0", pix_valid); end
        checks++; if ({frame_count, err_sof, err_eol} !== 32'h0) begin
            errors++; $display("FAIL rst_counters: got fc=%0d esof=%0d eeol=%0d, expected 0", frame_count, err_sof, err_eol);
        end
        @(negedge aclk); aresetn = 1'b1; in_if.tvalid = 1'b0;
    endtask

    task automatic test_line();
        pix_t g;
        clear_q();
        for (int k = 0; k < 6; k++) push_word(word_at(8'h10, k), k == 0, k == 5);
        for (int i = 0; i < 8; i++) push_exp(pix_at(8'h10, 0, i), i, 0, i == 0, i == 7);
        run_stream(6, 8, 1'b0, 1'b1);
        checks++; if (timed_out !== 1'b0 || got_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL line_count: got %0d pixels (timeout=%b), expected %0d", got_q.size(), timed_out, exp_q.size());
        end
        foreach (exp_q[i]) begin
            g = (i < got_q.size()) ? got_q[i] : '0;
            checks++; if (g !== exp_q[i]) begin
                errors++; $display("FAIL line_pix[%0d]: got %h/%0d/%0d/%b/%b, expected %h/%0d/%0d/%b/%b", i,
                    g.rgb, g.x, g.y, g.sof, g.eol, exp_q[i].rgb, exp_q[i].x, exp_q[i].y, exp_q[i].sof, exp_q[i].eol);
            end
        end
        checks++; if ({err_sof, err_eol} !== 16'h0 || frame_count !== 16'd1) begin
            errors++; $display("FAIL line_counters: got fc=%0d esof=%0d eeol=%0d, expected 1/0/0", frame_count, err_sof, err_eol);
        end
        checks++; if (p3_viol !== 0) begin errors++; $display("FAIL line_p3_tready: got %0d violations, expected 0", p3_viol); end
    endtask

    task automatic test_unpack();
        pix_t g;
        clear_q();
        push_word(32'h44332211, 1'b0, 1'b0); push_word(32'h88776655, 1'b0, 1'b0);
        push_word(32'hCCBBAA99, 1'b0, 1'b0); push_word(32'h04030201, 1'b0, 1'b0);
        push_word(32'h08070605, 1'b0, 1'b0); push_word(32'h0C0B0A09, 1'b0, 1'b1);
        push_exp(24'h332211, 0, 1, 1'b0, 1'b0); push_exp(24'h665544, 1, 1, 1'b0, 1'b0);
        push_exp(24'h998877, 2, 1, 1'b0, 1'b0); push_exp(24'hCCBBAA, 3, 1, 1'b0, 1'b0);
        push_exp(24'h030201, 4, 1, 1'b0, 1'b0); push_exp(24'h060504, 5, 1, 1'b0, 1'b0);
        push_exp(24'h090807, 6, 1, 1'b0, 1'b0); push_exp(24'h0C0B0A, 7, 1, 1'b0, 1'b1);
        run_stream(6, 8, 1'b0, 1'b1);
        checks++; if (timed_out !== 1'b0 || got_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL unpack_count: got %0d pixels (timeout=%b), expected %0d", got_q.size(), timed_out, exp_q.size());
        end
        foreach (exp_q[i]) begin
            g = (i < got_q.size()) ? got_q[i] : '0;
            checks++; if (g !== exp_q[i]) begin
                errors++; $display("FAIL unpack_pix[%0d]: got %h/%0d/%0d/%b/%b, expected %h/%0d/%0d/%b/%b", i,
                    g.rgb, g.x, g.y, g.sof, g.eol, exp_q[i].rgb, exp_q[i].x, exp_q[i].y, exp_q[i].sof, exp_q[i].eol);
            end
        end
        checks++; if (p3_viol !== 0 || p3_seen !== 2) begin
            errors++; $display("FAIL unpack_p3: got %0d violations over %0d held cycles, expected 0 over 2", p3_viol, p3_seen);
        end
    endtask

    task automatic test_backpressure();
        pix_t g;
        @(negedge aclk); aresetn = 1'b0; in_if.tvalid = 1'b0;
        @(negedge aclk); aresetn = 1'b1;
        clear_q();
        for (int k = 0; k < 24; k++) push_word(word_at(8'h31, k), k == 0, (k % 6) == 5);
        for (int i = 0; i < 32; i++) push_exp(pix_at(8'h31, 0, i), i % 8, i / 8, i == 0, (i % 8) == 7);
        run_stream(24, 32, 1'b1, 1'b1);
        checks++; if (timed_out !== 1'b0 || got_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL bp_count: got %0d pixels (timeout=%b), expected %0d", got_q.size(), timed_out, exp_q.size());
        end
        foreach (exp_q[i]) begin
            g = (i < got_q.size()) ? got_q[i] : '0;
            checks++; if (g !== exp_q[i]) begin
                errors++; $display("FAIL bp_pix[%0d]: got %h/%0d/%0d/%b/%b, expected %h/%0d/%0d/%b/%b", i,
                    g.rgb, g.x, g.y, g.sof, g.eol, exp_q[i].rgb, exp_q[i].x, exp_q[i].y, exp_q[i].sof, exp_q[i].eol);
            end
        end
        checks++; if (p3_viol !== 0) begin errors++; $display("FAIL bp_p3_tready: got %0d violations, expected 0", p3_viol); end
        checks++; if ({err_sof, err_eol} !== 16'h0 || frame_count !== 16'd1) begin
            errors++; $display("FAIL bp_counters: got fc=%0d esof=%0d eeol=%0d, expected 1/0/0", frame_count, err_sof, err_eol);
        end
    endtask

    task automatic test_sof_resync();
        pix_t g;
        clear_q();
        for (int k = 0; k < 8; k++) push_word(word_at(8'h52, k), (k == 0) || (k == 2), k == 7);
        push_exp(pix_at(8'h52, 0, 0), 0, 0, 1'b1, 1'b0);
        push_exp(pix_at(8'h52, 0, 1), 1, 0, 1'b0, 1'b0);
        for (int j = 0; j < 8; j++) push_exp(pix_at(8'h52, 8, j), j, 0, j == 0, j == 7);
        run_stream(8, 10, 1'b0, 1'b0);
        checks++; if (timed_out !== 1'b0 || got_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL sof_count: got %0d pixels (timeout=%b), expected %0d", got_q.size(), timed_out, exp_q.size());
        end
        foreach (exp_q[i]) begin
            g = (i < got_q.size()) ? got_q[i] : '0;
            checks++; if (g !== exp_q[i]) begin
                errors++; $display("FAIL sof_pix[%0d]: got %h/%0d/%0d/%b/%b, expected %h/%0d/%0d/%b/%b", i,
                    g.rgb, g.x, g.y, g.sof, g.eol, exp_q[i].rgb, exp_q[i].x, exp_q[i].y, exp_q[i].sof, exp_q[i].eol);
            end
        end
        checks++; if (err_sof !== 8'd1 || err_eol !== 8'd0 || frame_count !== 16'd3) begin
            errors++; $display("FAIL sof_counters: got fc=%0d esof=%0d eeol=%0d, expected 3/1/0", frame_count, err_sof, err_eol);
        end
    endtask

    task automatic test_eol_errors();
        pix_t g;
        clear_q();
        push_word(word_at(8'h63, 0), 1'b0, 1'b0); push_word(word_at(8'h63, 1), 1'b0, 1'b1);
        push_exp(pix_at(8'h63, 0, 0), 0, 1, 1'b0, 1'b0);
        push_exp(pix_at(8'h63, 0, 1), 1, 1, 1'b0, 1'b1);
        run_stream(2, 2, 1'b0, 1'b0);
        checks++; if (timed_out !== 1'b0 || got_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL eol_early_count: got %0d pixels (timeout=%b), expected %0d", got_q.size(), timed_out, exp_q.size());
        end
        foreach (exp_q[i]) begin
            g = (i < got_q.size()) ? got_q[i] : '0;
            checks++; if (g !== exp_q[i]) begin
                errors++; $display("FAIL eol_early_pix[%0d]: got %h/%0d/%0d/%b/%b, expected %h/%0d/%0d/%b/%b", i,
                    g.rgb, g.x, g.y, g.sof, g.eol, exp_q[i].rgb, exp_q[i].x, exp_q[i].y, exp_q[i].sof, exp_q[i].eol);
            end
        end
        checks++; if (err_eol !== 8'd1) begin errors++; $display("FAIL eol_early_cnt: got %0d, expected 1", err_eol); end
        clear_q();
        for (int k = 2; k < 8; k++) push_word(word_at(8'h63, k), 1'b0, 1'b0);
        for (int j = 0; j < 8; j++) push_exp(pix_at(8'h63, 8, j), j, 2, 1'b0, j == 7);
        run_stream(6, 8, 1'b0, 1'b0);
        checks++; if (timed_out !== 1'b0 || got_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL eol_miss_count: got %0d pixels (timeout=%b), expected %0d", got_q.size(), timed_out, exp_q.size());
        end
        foreach (exp_q[i]) begin
            g = (i < got_q.size()) ? got_q[i] : '0;
            checks++; if (g !== exp_q[i]) begin
                errors++; $display("FAIL eol_miss_pix[%0d]: got %h/%0d/%0d/%b/%b, expected %h/%0d/%0d/%b/%b", i,
                    g.rgb, g.x, g.y, g.sof, g.eol, exp_q[i].rgb, exp_q[i].x, exp_q[i].y, exp_q[i].sof, exp_q[i].eol);
            end
        end
        checks++; if (err_eol !== 8'd2 || err_sof !== 8'd1) begin
            errors++; $display("FAIL eol_miss_cnt: got eeol=%0d esof=%0d, expected 2/1", err_eol, err_sof);
        end
    endtask

    task automatic test_midline_reset();
        pix_t g;
        @(negedge aclk);
        in_if.tvalid = 1'b1; in_if.tdata = word_at(8'h70, 0); in_if.tuser = 1'b0; in_if.tlast = 1'b0;
        pix_ready = 1'b0;
        @(negedge aclk);
        in_if.tvalid = 1'b0;
        checks++; if (pix_valid !== 1'b1) begin errors++; $display("FAIL mrst_pre_valid: got %b, expected 1", pix_valid); end
        aresetn = 1'b0;
        @(posedge aclk); #1;
        checks++; if (pix_valid !== 1'b0 || in_if.tready !== 1'b0) begin
            errors++; $display("FAIL mrst_outputs: got valid=%b tready=%b, expected 0/0", pix_valid, in_if.tready);
        end
        checks++; if ({frame_count, err_sof, err_eol} !== 32'h0) begin
            errors++; $display("FAIL mrst_counters: got fc=%0d esof=%0d eeol=%0d, expected 0", frame_count, err_sof, err_eol);
        end
        @(negedge aclk); aresetn = 1'b1; pix_ready = 1'b1;
        clear_q();
        for (int k = 0; k < 6; k++) push_word(word_at(8'h90, k), k == 0, k == 5);
        for (int i = 0; i < 8; i++) push_exp(pix_at(8'h90, 0, i), i, 0, i == 0, i == 7);
        run_stream(6, 8, 1'b0, 1'b1);
        checks++; if (timed_out !== 1'b0 || got_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL mrst_count: got %0d pixels (timeout=%b), expected %0d", got_q.size(), timed_out, exp_q.size());
        end
        foreach (exp_q[i]) begin
            g = (i < got_q.size()) ? got_q[i] : '0;
            checks++; if (g !== exp_q[i]) begin
                errors++; $display("FAIL mrst_pix[%0d]: got %h/%0d/%0d/%b/%b, expected %h/%0d/%0d/%b/%b", i,
                    g.rgb, g.x, g.y, g.sof, g.eol, exp_q[i].rgb, exp_q[i].x, exp_q[i].y, exp_q[i].sof, exp_q[i].eol);
            end
        end
        checks++; if ({err_sof, err_eol} !== 16'h0 || frame_count !== 16'd1) begin
            errors++; $display("FAIL mrst_after: got fc=%0d esof=%0d eeol=%0d, expected 1/0/0", frame_count, err_sof, err_eol);
        end
    endtask

    initial begin
        test_reset();
        test_line();
        test_unpack();
        test_backpressure();
        test_sof_resync();
        test_eol_errors();
        test_midline_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
